// File: rtl/addsub_pipe.sv
// Pipelined N-bit two's-complement adder/subtractor: the carry chain is cut into
// STAGES chunks of W bits, one registered chunk per stage, with valid/ready flow control.
`timescale 1ns/1ps
module addsub_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int W    = N / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage beat state: operands travel along so later chunks can still use them.
    logic [N-1:0]      r_a   [STAGES];
    logic [N-1:0]      r_bx  [STAGES];
    logic [N-1:0]      r_sum [STAGES];
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic              r_cm;

    logic [N-1:0]      w_a_src   [STAGES];
    logic [N-1:0]      w_bx_src  [STAGES];
    logic [N-1:0]      w_sum_src [STAGES];
    logic [N-1:0]      w_sum_nxt [STAGES];
    logic [W:0]        w_chunk   [STAGES];
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic              w_cm_nxt;

    // Select each stage's inputs: ports feed stage 0, the previous stage feeds the rest.
    always_comb begin
        w_a_src[0]   = a;
        w_bx_src[0]  = b ^ {N{m}};
        w_sum_src[0] = {N{1'b0}};
        w_cin[0]     = m;
        w_vin[0]     = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_src[k]   = r_a[k-1];
            w_bx_src[k]  = r_bx[k-1];
            w_sum_src[k] = r_sum[k-1];
            w_cin[k]     = r_c[k-1];
            w_vin[k]     = w_adv[k-1];
        end
    end

    // Chunk adders; the carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = {1'b0, w_a_src[k][k*W +: W]}
                       + {1'b0, w_bx_src[k][k*W +: W]}
                       + {{W{1'b0}}, w_cin[k]};
            w_sum_nxt[k]             = w_sum_src[k];
            w_sum_nxt[k][k*W +: W]   = w_chunk[k][W-1:0];
        end
        w_cm_nxt = w_chunk[LAST][W-1] ^ w_a_src[LAST][N-1] ^ w_bx_src[LAST][N-1];
    end

    // Advance chain runs back from the output so a full pipe can drain and fill in one cycle.
    always_comb begin
        w_adv        = {STAGES{1'b0}};
        w_load       = {STAGES{1'b0}};
        w_adv[LAST]  = r_v[LAST] && out_ready;
        w_load[LAST] = !r_v[LAST] || w_adv[LAST];
        for (int k = LAST - 1; k >= 0; k--) begin
            w_adv[k]  = r_v[k] && w_load[k+1];
            w_load[k] = !r_v[k] || w_adv[k];
        end
    end

    // Stage registers: a free stage takes whatever its source offers this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= {STAGES{1'b0}};
            r_c  <= {STAGES{1'b0}};
            r_cm <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= {N{1'b0}};
                r_bx[k]  <= {N{1'b0}};
                r_sum[k] <= {N{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_a[k]   <= w_a_src[k];
                        r_bx[k]  <= w_bx_src[k];
                        r_sum[k] <= w_sum_nxt[k];
                        r_c[k]   <= w_chunk[k][W];
                    end
                end
            end
            if (w_load[LAST] && w_vin[LAST]) begin
                r_cm <= w_cm_nxt;
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[LAST];
    assign sum       = r_sum[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_cm ^ r_c[LAST];
    assign zero      = (r_sum[LAST] == {N{1'b0}});
    assign neg       = r_sum[LAST][N-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: one 8-bit/2-stage instance for directed cases and
// two 16-bit instances (1 and 4 stages) for a random sweep with random back-pressure.
`timescale 1ns/1ps
module tb_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  t_iv;
    logic [2:0]  t_or;
    logic [2:0]  t_m;
    logic [15:0] t_a [3];
    logic [15:0] t_b [3];
    wire  [2:0]  w_ir, w_ov, w_co, w_of, w_z, w_ng;
    wire  [7:0]  w_sum0;
    wire  [15:0] w_sum1, w_sum2;

    addsub_pipe #(.N(8), .STAGES(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(t_iv[0]), .in_ready(w_ir[0]),
        .a(t_a[0][7:0]), .b(t_b[0][7:0]), .m(t_m[0]), .out_valid(w_ov[0]),
        .out_ready(t_or[0]), .sum(w_sum0), .cout(w_co[0]), .ovf(w_of[0]),
        .zero(w_z[0]), .neg(w_ng[0]));

    addsub_pipe #(.N(16), .STAGES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(t_iv[1]), .in_ready(w_ir[1]),
        .a(t_a[1]), .b(t_b[1]), .m(t_m[1]), .out_valid(w_ov[1]),
        .out_ready(t_or[1]), .sum(w_sum1), .cout(w_co[1]), .ovf(w_of[1]),
        .zero(w_z[1]), .neg(w_ng[1]));

    addsub_pipe #(.N(16), .STAGES(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(t_iv[2]), .in_ready(w_ir[2]),
        .a(t_a[2]), .b(t_b[2]), .m(t_m[2]), .out_valid(w_ov[2]),
        .out_ready(t_or[2]), .sum(w_sum2), .cout(w_co[2]), .ovf(w_of[2]),
        .zero(w_z[2]), .neg(w_ng[2]));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stages_of [3] = '{2, 1, 4};
    int width_of  [3] = '{8, 16, 16};
    logic [19:0] q_exp [3][$];
    int          q_acc [3][$];
    int n_push [3];
    int n_pop  [3];
    int last_stall [3];
    int pop_cyc [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, ovf, zero, neg, sum} from integer arithmetic on n-bit operands.
    function automatic logic [19:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                          input logic m);
        int ua, ub, sa, sb, rs, lim;
        logic [15:0] s;
        logic c, v;
        lim = 1 << n;
        ua  = int'(a) & (lim - 1);
        ub  = int'(b) & (lim - 1);
        s   = 16'((m ? ua - ub : ua + ub) & (lim - 1));
        c   = m ? (ua >= ub) : ((ua + ub) >= lim);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        rs  = m ? sa - sb : sa + sb;
        v   = (rs >= lim / 2) || (rs < -(lim / 2));
        return {c, v, (s == 16'd0), s[n-1], s};
    endfunction

    function automatic logic [19:0] obs_of(input int d);
        case (d)
            0:       return {w_co[0], w_of[0], w_z[0], w_ng[0], 8'h00, w_sum0};
            1:       return {w_co[1], w_of[1], w_z[1], w_ng[1], w_sum1};
            default: return {w_co[2], w_of[2], w_z[2], w_ng[2], w_sum2};
        endcase
    endfunction

    // Observe the handshakes the coming rising edge will act on.
    task automatic mon(input int d);
        logic [19:0] e;
        int acc;
        if (!t_or[d]) last_stall[d] = cyc;
        if (w_ov[d] && t_or[d]) begin
            n_pop[d]++;
            if (d == 0) pop_cyc.push_back(cyc);
            check_val($sformatf("d%0d_result_expected", d), 32'(q_exp[d].size() != 0), 32'd1);
            if (q_exp[d].size() != 0) begin
                e   = q_exp[d].pop_front();
                acc = q_acc[d].pop_front();
                check_val($sformatf("d%0d_result", d), 32'(obs_of(d)), 32'(e));
                if (last_stall[d] <= acc)
                    check_val($sformatf("d%0d_latency", d), 32'(cyc - acc), 32'(stages_of[d]));
            end
        end
        if (t_iv[d] && w_ir[d] && rst_n) begin
            q_exp[d].push_back(model(width_of[d], t_a[d], t_b[d], t_m[d]));
            q_acc[d].push_back(cyc);
            n_push[d]++;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) mon(d);
        cyc++;
    end

    // Present one beat and hold it until accepted or the budget runs out; entered at posedge+1.
    task automatic send(input int d, input logic [15:0] a, input logic [15:0] b, input logic m,
                        input int budget, output bit ok);
        ok = 1'b0;
        t_a[d] = a; t_b[d] = b; t_m[d] = m; t_iv[d] = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            #1;
            if (w_ir[d]) ok = 1'b1;
            @(posedge clk); #1;
        end
        t_iv[d] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] dir_a [6] = '{16'd100, 16'h7F, 16'hFF, 16'd5, 16'd3, 16'h80};
    logic [15:0] dir_b [6] = '{16'd27,  16'h01, 16'h01, 16'd5, 16'd5, 16'h01};
    logic        dir_m [6] = '{1'b0,    1'b0,   1'b0,   1'b1,  1'b1,  1'b1};

    initial begin
        bit ok;
        logic [7:0]  hold;
        logic [19:0] exp_head;
        int np, ps;
        int sent [3];
        bit acc_f [3];
        bit done;

        rst_n = 1'b0; t_iv = 3'b000; t_or = 3'b000; t_m = 3'b000;
        for (int d = 0; d < 3; d++) begin
            t_a[d] = 16'h0000; t_b[d] = 16'h0000; last_stall[d] = -1;
            n_push[d] = 0; n_pop[d] = 0; sent[d] = 0; acc_f[d] = 1'b0;
        end

        #2;
        check_val("rst_out_valid", 32'(w_ov), 32'd0);
        check_val("rst_sum",       32'(w_sum0), 32'd0);
        check_val("rst_flags",     32'({w_co[0], w_of[0], w_z[0], w_ng[0]}), 32'b0010);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_val("rst_in_ready", 32'(w_ir), 32'b111);

        // Directed arithmetic cases, back to back with the consumer always ready.
        @(posedge clk); #1;
        t_or[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(0, dir_a[i], dir_b[i], dir_m[i], 4, ok);
            check_val("dir_accept", 32'(ok), 32'd1);
        end
        cycles(5);

        // Back-pressure: two beats fill the pipe, the third is refused.
        t_or[0] = 1'b0;
        send(0, 16'd10, 16'd20, 1'b0, 4, ok);
        check_val("bp_accept1", 32'(ok), 32'd1);
        send(0, 16'd200, 16'd100, 1'b1, 4, ok);
        check_val("bp_accept2", 32'(ok), 32'd1);
        send(0, 16'h55, 16'hAA, 1'b0, 3, ok);
        check_val("bp_third_refused", 32'(ok), 32'd0);
        check_val("bp_in_ready", 32'(w_ir[0]), 32'd0);
        check_val("bp_out_valid", 32'(w_ov[0]), 32'd1);
        exp_head = model(8, 16'd10, 16'd20, 1'b0);
        check_val("bp_head", 32'(w_sum0), 32'(exp_head[7:0]));
        hold = w_sum0;
        cycles(3);
        check_val("bp_hold", 32'(w_sum0), 32'(hold));
        t_or[0] = 1'b1;
        np = n_pop[0];
        send(0, 16'h55, 16'hAA, 1'b0, 2, ok);
        check_val("bp_accept3", 32'(ok), 32'd1);
        send(0, 16'h40, 16'h40, 1'b0, 2, ok);
        check_val("bp_accept4", 32'(ok), 32'd1);
        cycles(4);
        check_val("bp_drained", 32'(n_pop[0] - np), 32'd4);
        ps = pop_cyc.size();
        if (ps >= 4) begin
            for (int i = 0; i < 3; i++)
                check_val("bp_consecutive", 32'(pop_cyc[ps-3+i] - pop_cyc[ps-4+i]), 32'd1);
        end

        // Reset with two beats in flight.
        t_or[0] = 1'b0;
        send(0, 16'd1, 16'd2, 1'b0, 4, ok);
        send(0, 16'd3, 16'd4, 1'b0, 4, ok);
        check_val("mid_inflight", 32'(w_ov[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 32'(w_ov[0]), 32'd0);
        check_val("mid_rst_sum", 32'(w_sum0), 32'd0);
        check_val("mid_rst_zero", 32'(w_z[0]), 32'd1);
        for (int d = 0; d < 3; d++) begin
            q_exp[d].delete();
            q_acc[d].delete();
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check_val("mid_in_ready", 32'(w_ir[0]), 32'd1);
        t_or[0] = 1'b1;
        np = n_pop[0];
        cycles(5);
        check_val("mid_no_stale", 32'(n_pop[0] - np), 32'd0);

        // Random sweep on the 16-bit instances with random valid and ready.
        done = 1'b0;
        for (int c = 0; c < 30000 && !done; c++) begin
            for (int d = 1; d < 3; d++) begin
                if (t_iv[d] && acc_f[d]) t_iv[d] = 1'b0;
                if (!t_iv[d] && sent[d] < 1000 && $urandom_range(0, 3) != 0) begin
                    t_a[d]  = 16'($urandom);
                    t_b[d]  = 16'($urandom);
                    t_m[d]  = 1'($urandom_range(0, 1));
                    t_iv[d] = 1'b1;
                end
                t_or[d] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int d = 1; d < 3; d++) begin
                acc_f[d] = t_iv[d] && w_ir[d];
                if (acc_f[d]) sent[d]++;
            end
            @(posedge clk); #1;
            t_iv[1] = t_iv[1] && !acc_f[1];
            t_iv[2] = t_iv[2] && !acc_f[2];
            acc_f[1] = 1'b0; acc_f[2] = 1'b0;
            done = (sent[1] >= 1000) && (sent[2] >= 1000)
                && (q_exp[1].size() == 0) && (q_exp[2].size() == 0);
        end
        for (int d = 1; d < 3; d++) begin
            check_val($sformatf("d%0d_sweep_sent", d), 32'(sent[d]), 32'd1000);
            check_val($sformatf("d%0d_sweep_drained", d), 32'(q_exp[d].size()), 32'd0);
            check_val($sformatf("d%0d_push_pop", d), 32'(n_pop[d]), 32'(n_push[d]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
